// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset controller: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath control fields for each state.
module mc_controller #(
    parameter int MEM_WAIT_EN = 1,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic [2:0] NPCOp,
    output logic [1:0] EXTOp,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       MemWrite,
    output logic [1:0] MemtoReg,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             timeoutErr_q, timeoutErr_d;

    logic rdy, limitHit;
    logic isRType, isNop, isAdd, isSub, isJr, isOri, isLui, isLw, isSw, isBeq, isJal;

    assign rdy      = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign limitHit = (TIMEOUT > 0) && (waitCnt_q == LIMIT) && !rdy;

    assign isRType = (opcode == 6'b000000);
    assign isNop   = isRType && (funct == 6'b000000);
    assign isAdd   = isRType && (funct == 6'b100000);
    assign isSub   = isRType && (funct == 6'b100010);
    assign isJr    = isRType && (funct == 6'b001000);
    assign isOri   = (opcode == 6'b001101);
    assign isLui   = (opcode == 6'b001111);
    assign isLw    = (opcode == 6'b100011);
    assign isSw    = (opcode == 6'b101011);
    assign isBeq   = (opcode == 6'b000100);
    assign isJal   = (opcode == 6'b000011);

    assign state       = state_q;
    assign timeout_err = timeoutErr_q;

    always_comb begin
        mem_req      = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        NPCOp        = 3'b000;
        EXTOp        = 2'b00;
        RegDst       = 2'b00;
        RegWrite     = 1'b0;
        ALUSrc       = 1'b0;
        ALUOp        = 2'b00;
        MemWrite     = 1'b0;
        MemtoReg     = 2'b00;
        instr_done   = 1'b0;
        state_d      = state_q;
        waitCnt_d    = '0;
        timeoutErr_d = timeoutErr_q;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (limitHit) begin
                    timeoutErr_d = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (isAdd || isSub || isJr || isOri || isLui ||
                    isLw || isSw || isBeq || isJal) begin
                    state_d = S_EXEC;
                end else begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (isAdd || isSub) begin
                    ALUOp   = isSub ? 2'b01 : 2'b00;
                    state_d = S_WB;
                end else if (isOri || isLui) begin
                    EXTOp   = isLui ? 2'b10 : 2'b00;
                    ALUSrc  = 1'b1;
                    ALUOp   = 2'b10;
                    state_d = S_WB;
                end else if (isLw || isSw) begin
                    EXTOp   = 2'b01;
                    ALUSrc  = 1'b1;
                    state_d = S_MEM;
                end else if (isBeq) begin
                    ALUOp      = 2'b01;
                    NPCOp      = 3'b001;
                    PCWrite    = zero;
                    instr_done = 1'b1;
                end else if (isJr) begin
                    NPCOp      = 3'b011;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end else if (isJal) begin
                    NPCOp      = 3'b010;
                    PCWrite    = 1'b1;
                    RegDst     = 2'b10;
                    MemtoReg   = 2'b10;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (rdy) begin
                    MemWrite = isSw;
                    if (isLw) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (limitHit) begin
                    timeoutErr_d = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                RegDst     = (isAdd || isSub) ? 2'b01 : 2'b00;
                MemtoReg   = isLw ? 2'b01 : 2'b00;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every strobe so an interrupted instruction writes nothing.
        if (reset) begin
            mem_req    = 1'b0;
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            waitCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one instance with memory waits and TIMEOUT=4,
// one with MEM_WAIT_EN=0 for the wait-free lw sequence.
module tb_mc_controller;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] FN_ADD = 6'b100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, reset0, memReady, memReady0, zero;
    logic [5:0] opcode, funct;

    logic       mem_req, PCWrite, IRWrite, RegWrite, ALUSrc, MemWrite, instr_done, timeout_err;
    logic [2:0] NPCOp, state;
    logic [1:0] EXTOp, RegDst, ALUOp, MemtoReg;

    logic       memReq0, pcWrite0, irWrite0, regWrite0, aluSrc0, memWrite0, instrDone0, timeoutErr0;
    logic [2:0] npcOp0, state0;
    logic [1:0] extOp0, regDst0, aluOp0, memtoReg0;

    int checks = 0;
    int errors = 0;

    mc_controller #(.MEM_WAIT_EN(1), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(memReady), .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .NPCOp(NPCOp), .EXTOp(EXTOp), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .state(state), .instr_done(instr_done), .timeout_err(timeout_err)
    );

    mc_controller #(.MEM_WAIT_EN(0), .TIMEOUT(16), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset0), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(memReady0), .mem_req(memReq0), .PCWrite(pcWrite0), .IRWrite(irWrite0),
        .NPCOp(npcOp0), .EXTOp(extOp0), .RegDst(regDst0), .RegWrite(regWrite0),
        .ALUSrc(aluSrc0), .ALUOp(aluOp0), .MemWrite(memWrite0), .MemtoReg(memtoReg0),
        .state(state0), .instr_done(instrDone0), .timeout_err(timeoutErr0)
    );

    // Drive one cycle of inputs on the falling edge and let the outputs settle.
    task automatic applyStimulus(input logic rst, input logic rst0, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z, input logic rdy,
                                 input logic rdy0);
        @(negedge clk);
        reset     = rst;
        reset0    = rst0;
        opcode    = op;
        funct     = fn;
        zero      = z;
        memReady  = rdy;
        memReady0 = rdy0;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; reset0 = 1'b1; memReady = 1'b0; memReady0 = 1'b0;
        zero = 1'b0; opcode = OP_LW; funct = 6'd0;

        // lw on the wait-free instance, mem_ready held low throughout
        applyStimulus(1, 1, OP_LW, 6'd0, 0, 0, 0);
        applyStimulus(1, 0, OP_LW, 6'd0, 0, 0, 0);
        checkOutput("lw0_fetch_state", state0, 0);
        checkOutput("lw0_fetch_irwrite", irWrite0, 1);
        checkOutput("lw0_fetch_memreq", memReq0, 1);
        applyStimulus(1, 0, OP_LW, 6'd0, 0, 0, 0);
        checkOutput("lw0_decode_state", state0, 1);
        applyStimulus(1, 0, OP_LW, 6'd0, 0, 0, 0);
        checkOutput("lw0_exec_state", state0, 2);
        checkOutput("lw0_exec_extop", extOp0, 1);
        checkOutput("lw0_exec_alusrc", aluSrc0, 1);
        applyStimulus(1, 0, OP_LW, 6'd0, 0, 0, 0);
        checkOutput("lw0_mem_state", state0, 3);
        checkOutput("lw0_mem_memwrite", memWrite0, 0);
        checkOutput("lw0_mem_done", instrDone0, 0);
        applyStimulus(1, 0, OP_LW, 6'd0, 0, 0, 0);
        checkOutput("lw0_wb_state", state0, 4);
        checkOutput("lw0_wb_regwrite", regWrite0, 1);
        checkOutput("lw0_wb_memtoreg", memtoReg0, 1);
        checkOutput("lw0_wb_done", instrDone0, 1);
        applyStimulus(1, 1, OP_LW, 6'd0, 0, 0, 0);
        checkOutput("lw0_back_fetch", state0, 0);
        checkOutput("lw0_done_reset", instrDone0, 0);

        // Reset held three cycles with lw on the bus and mem_ready high
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, OP_LW, 6'd0, 0, 1, 0);
            checkOutput("rst_state", state, 0);
            checkOutput("rst_memreq", mem_req, 0);
            checkOutput("rst_irwrite", IRWrite, 0);
            checkOutput("rst_pcwrite", PCWrite, 0);
            checkOutput("rst_regwrite", RegWrite, 0);
            checkOutput("rst_memwrite", MemWrite, 0);
            checkOutput("rst_done", instr_done, 0);
            checkOutput("rst_timeout", timeout_err, 0);
        end

        // beq taken, then not taken
        applyStimulus(0, 1, OP_BEQ, 6'd0, 1, 1, 0);
        checkOutput("beq1_fetch_memreq", mem_req, 1);
        checkOutput("beq1_fetch_irwrite", IRWrite, 1);
        checkOutput("beq1_fetch_pcwrite", PCWrite, 1);
        checkOutput("beq1_fetch_npcop", NPCOp, 0);
        applyStimulus(0, 1, OP_BEQ, 6'd0, 1, 1, 0);
        checkOutput("beq1_decode_state", state, 1);
        checkOutput("beq1_decode_done", instr_done, 0);
        applyStimulus(0, 1, OP_BEQ, 6'd0, 1, 1, 0);
        checkOutput("beq1_exec_state", state, 2);
        checkOutput("beq1_exec_pcwrite", PCWrite, 1);
        checkOutput("beq1_exec_npcop", NPCOp, 1);
        checkOutput("beq1_exec_done", instr_done, 1);
        checkOutput("beq1_exec_regwrite", RegWrite, 0);
        applyStimulus(0, 1, OP_BEQ, 6'd0, 0, 1, 0);
        checkOutput("beq0_fetch_state", state, 0);
        checkOutput("beq0_fetch_irwrite", IRWrite, 1);
        applyStimulus(0, 1, OP_BEQ, 6'd0, 0, 1, 0);
        checkOutput("beq0_decode_state", state, 1);
        applyStimulus(0, 1, OP_BEQ, 6'd0, 0, 1, 0);
        checkOutput("beq0_exec_state", state, 2);
        checkOutput("beq0_exec_pcwrite", PCWrite, 0);
        checkOutput("beq0_exec_done", instr_done, 1);

        // sw with three wait cycles in MEM; ready arrives on the limit cycle
        applyStimulus(0, 1, OP_SW, 6'd0, 0, 1, 0);
        checkOutput("sw_fetch_state", state, 0);
        checkOutput("sw_fetch_irwrite", IRWrite, 1);
        applyStimulus(0, 1, OP_SW, 6'd0, 0, 1, 0);
        checkOutput("sw_decode_state", state, 1);
        applyStimulus(0, 1, OP_SW, 6'd0, 0, 1, 0);
        checkOutput("sw_exec_state", state, 2);
        checkOutput("sw_exec_extop", EXTOp, 1);
        checkOutput("sw_exec_alusrc", ALUSrc, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, OP_SW, 6'd0, 0, 0, 0);
            checkOutput("sw_wait_state", state, 3);
            checkOutput("sw_wait_memwrite", MemWrite, 0);
            checkOutput("sw_wait_memreq", mem_req, 1);
            checkOutput("sw_wait_done", instr_done, 0);
        end
        applyStimulus(0, 1, OP_SW, 6'd0, 0, 1, 0);
        checkOutput("sw_ready_state", state, 3);
        checkOutput("sw_ready_memwrite", MemWrite, 1);
        checkOutput("sw_ready_done", instr_done, 1);
        checkOutput("sw_ready_timeout", timeout_err, 0);

        // Fetch timeout: four wait cycles with mem_ready low
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 0, 0);
        checkOutput("sw_after_state", state, 0);
        checkOutput("sw_after_memwrite", MemWrite, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, OP_R, FN_ADD, 0, 0, 0);
            checkOutput("to_wait_state", state, 0);
            checkOutput("to_wait_irwrite", IRWrite, 0);
            checkOutput("to_wait_timeout", timeout_err, 0);
        end
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 0, 0);
        checkOutput("to_set_state", state, 0);
        checkOutput("to_set_timeout", timeout_err, 1);
        checkOutput("to_set_irwrite", IRWrite, 0);

        // Error stays sticky across a nop
        applyStimulus(0, 1, OP_R, 6'd0, 0, 1, 0);
        checkOutput("nop_fetch_irwrite", IRWrite, 1);
        checkOutput("nop_fetch_timeout", timeout_err, 1);
        applyStimulus(0, 1, OP_R, 6'd0, 0, 1, 0);
        checkOutput("nop_decode_state", state, 1);
        checkOutput("nop_decode_done", instr_done, 1);
        applyStimulus(0, 1, OP_R, 6'd0, 0, 1, 0);
        checkOutput("nop_back_state", state, 0);
        checkOutput("nop_sticky_timeout", timeout_err, 1);

        // Reset clears the error; then ready on the fourth fetch wait cycle
        applyStimulus(1, 1, OP_R, FN_ADD, 0, 0, 0);
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 0, 0);
        checkOutput("lim_cleared_timeout", timeout_err, 0);
        checkOutput("lim_state", state, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, OP_R, FN_ADD, 0, 0, 0);
            checkOutput("lim_wait_irwrite", IRWrite, 0);
        end
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 1, 0);
        checkOutput("lim_ready_irwrite", IRWrite, 1);
        checkOutput("lim_ready_pcwrite", PCWrite, 1);
        checkOutput("lim_ready_timeout", timeout_err, 0);
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 1, 0);
        checkOutput("add_decode_state", state, 1);
        checkOutput("add_decode_timeout", timeout_err, 0);
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 1, 0);
        checkOutput("add_exec_state", state, 2);
        checkOutput("add_exec_aluop", ALUOp, 0);
        checkOutput("add_exec_alusrc", ALUSrc, 0);
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 1, 0);
        checkOutput("add_wb_state", state, 4);
        checkOutput("add_wb_regwrite", RegWrite, 1);
        checkOutput("add_wb_regdst", RegDst, 1);
        checkOutput("add_wb_done", instr_done, 1);
        applyStimulus(0, 1, OP_R, FN_ADD, 0, 1, 0);
        checkOutput("add_back_state", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
